// File: rtl/det_pattern_seq_if.sv
// Pattern-memory pins and the downstream pattern stream of det_pattern_seq.
// master = sequencer side, slave = memory/consumer side.
interface det_pattern_seq_if #(
  parameter int word_size    = 8,
  parameter int address_bits = 8
);
  logic                    mem_EN;
  logic                    mem_RW;
  logic [address_bits-1:0] mem_add;
  logic [word_size-1:0]    mem_data;
  // Stream handshake: a pattern moves on a rising edge where pat_valid and
  // pat_ready are both 1; pat_data is held stable while valid && !ready.
  logic                    pat_valid;
  logic [word_size-1:0]    pat_data;
  logic                    pat_ready;

  modport master (
    output mem_EN, mem_RW, mem_add,
    input  mem_data,
    output pat_valid, pat_data,
    input  pat_ready
  );

  modport slave (
    input  mem_EN, mem_RW, mem_add,
    output mem_data,
    input  pat_valid, pat_data,
    output pat_ready
  );
endinterface

// File: rtl/det_pattern_seq.sv
// Walks an address window of the deterministic pattern memory and streams the
// patterns out in order, hiding the one-cycle read latency in a 2-entry FIFO.
module det_pattern_seq #(
  parameter int word_size    = 8,
  parameter int address_bits = 8,
  parameter int mem_size     = 2 ** address_bits
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [address_bits-1:0] base_addr,
  input  logic [address_bits:0]   num_pat,
  output logic [address_bits:0]   pat_idx,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state,
  det_pattern_seq_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [address_bits:0] mem_size_w = (address_bits + 1)'(mem_size);
  localparam logic [address_bits:0] one_w      = (address_bits + 1)'(1);

  state_t                  state, state_nx;
  logic [address_bits-1:0] base_q;
  logic [address_bits:0]   num_q;
  logic [address_bits:0]   issued;
  logic                    inflight;
  logic [1:0]              count;
  logic                    rd_ptr, wr_ptr;
  logic [word_size-1:0]    buf_q [2];
  logic                    pop, issue, last_pop;
  logic [2:0]              occ_after;
  logic [address_bits:0]   addr_sum, addr_wrap;

  assign pop       = (count != 2'd0) && bus.pat_ready;
  // Occupancy the buffer will have once the in-flight read lands and this
  // cycle's transfer leaves; a new read is only safe while this stays below 2.
  assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign addr_sum  = {1'b0, base_q} + issued;
  assign addr_wrap = (addr_sum >= mem_size_w) ? addr_sum - mem_size_w : addr_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    last_pop = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && start) state_nx = (num_pat == '0) ? IDLE : FETCH;
      end
      FETCH: begin
        busy  = 1'b1;
        issue = !abort && (occ_after < 3'd2);
        if (abort)                               state_nx = IDLE;
        else if (issue && (issued + one_w == num_q)) state_nx = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        last_pop = pop && (count == 2'd1) && !inflight;
        if (abort || last_pop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      num_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      pat_idx  <= '0;
      done     <= 1'b0;
    end else if (abort) begin
      // Flushing inflight drops the read issued last cycle.
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        base_q  <= base_addr;
        num_q   <= num_pat;
        issued  <= '0;
        pat_idx <= '0;
        done    <= (num_pat == '0);
      end
      if (issue) issued <= issued + one_w;
      inflight <= issue;
      if (inflight) begin
        buf_q[wr_ptr] <= bus.mem_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        pat_idx <= pat_idx + one_w;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
      if (last_pop) done <= 1'b1;
    end
  end

  assign bus.mem_EN    = issue;
  assign bus.mem_RW    = 1'b0;
  assign bus.mem_add   = (state == FETCH) ? addr_wrap[address_bits-1:0] : '0;
  assign bus.pat_valid = (count != 2'd0);
  assign bus.pat_data  = buf_q[rd_ptr];
  assign dbg_state     = state;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(count == 2'd2 && inflight && !pop && !abort));

endmodule

// File: tb/tb_det_pattern_seq.sv
// Directed bench for det_pattern_seq with a 16-word pattern memory (word[i] = i).
module tb_det_pattern_seq;
  localparam int WS = 8;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AB-1:0] base_addr = '0;
  logic [AB:0]   num_pat = '0;
  logic [AB:0]   pat_idx;
  logic          busy, done;
  logic [1:0]    dbg_state;

  det_pattern_seq_if #(.word_size(WS), .address_bits(AB)) bus ();

  det_pattern_seq #(.word_size(WS), .address_bits(AB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .num_pat(num_pat), .pat_idx(pat_idx),
    .busy(busy), .done(done), .dbg_state(dbg_state), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // pattern memory model: one-cycle read latency
  logic [WS-1:0] mem [16];
  logic [WS-1:0] mem_q = '0;
  assign bus.mem_data = mem_q;
  always @(posedge clk) if (bus.mem_EN) mem_q <= mem[bus.mem_add];

  // monitor / scoreboard storage
  logic [WS-1:0] got_q[$];
  logic [WS-1:0] exp_q[$];
  logic [AB-1:0] addr_q[$];
  int rd_cnt [16];
  int occ = 0;
  int max_occ = 0;
  bit rw_seen = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.pat_valid && bus.pat_ready) got_q.push_back(bus.pat_data);
      if (bus.mem_EN) begin
        addr_q.push_back(bus.mem_add);
        rd_cnt[bus.mem_add] = rd_cnt[bus.mem_add] + 1;
      end
      occ = occ + (bus.mem_EN ? 1 : 0) - ((bus.pat_valid && bus.pat_ready) ? 1 : 0);
      if (occ > max_occ) max_occ = occ;
    end
    if (bus.mem_RW !== 1'b0) rw_seen = 1;
  end

  // driver tasks
  task automatic do_start(input logic [AB-1:0] b, input logic [AB:0] n);
    @(negedge clk);
    got_q.delete();
    addr_q.delete();
    occ = 0;
    max_occ = 0;
    for (int i = 0; i < 16; i++) rd_cnt[i] = 0;
    start = 1'b1;
    base_addr = b;
    num_pat = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.pat_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mem_EN !== 1'b0) begin failures++; $display("FAIL reset_mem_EN got=%0h exp=0", bus.mem_EN); end
    checks++; if (bus.mem_add !== 4'd0) begin failures++; $display("FAIL reset_mem_add got=%0h exp=0", bus.mem_add); end
    checks++; if (bus.pat_valid !== 1'b0) begin failures++; $display("FAIL reset_pat_valid got=%0h exp=0", bus.pat_valid); end
    checks++; if (bus.pat_data !== 8'd0) begin failures++; $display("FAIL reset_pat_data got=%0h exp=0", bus.pat_data); end
    checks++; if (pat_idx !== 5'd0) begin failures++; $display("FAIL reset_pat_idx got=%0h exp=0", pat_idx); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%0b%0b exp=00", busy, done); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0h exp=0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    bus.pat_ready = 1'b1;
    do_start(4'd4, 5'd3);
    checks++; if (bus.mem_EN !== 1'b1 || bus.mem_add !== 4'd4) begin failures++; $display("FAIL basic_first_read got=%0b/%0h exp=1/4", bus.mem_EN, bus.mem_add); end
    checks++; if (busy !== 1'b1 || bus.pat_valid !== 1'b0) begin failures++; $display("FAIL basic_k0 busy/valid got=%0b/%0b exp=1/0", busy, bus.pat_valid); end
    @(posedge clk); #1;
    checks++; if (bus.pat_valid !== 1'b0 || bus.mem_add !== 4'd5) begin failures++; $display("FAIL basic_k1 valid/add got=%0b/%0h exp=0/5", bus.pat_valid, bus.mem_add); end
    @(posedge clk); #1;
    checks++; if (bus.pat_valid !== 1'b1 || bus.pat_data !== 8'd4) begin failures++; $display("FAIL basic_k2 got=%0b/%0h exp=1/4", bus.pat_valid, bus.pat_data); end
    @(posedge clk); #1;
    checks++; if (bus.pat_data !== 8'd5 || pat_idx !== 5'd1) begin failures++; $display("FAIL basic_k3 data/idx got=%0h/%0d exp=5/1", bus.pat_data, pat_idx); end
    @(posedge clk); #1;
    checks++; if (bus.pat_data !== 8'd6 || done !== 1'b0) begin failures++; $display("FAIL basic_k4 data/done got=%0h/%0b exp=6/0", bus.pat_data, done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.pat_valid !== 1'b0) begin failures++; $display("FAIL basic_k5 done/busy/valid got=%0b/%0b/%0b exp=1/0/0", done, busy, bus.pat_valid); end
    checks++; if (pat_idx !== 5'd3 || dbg_state !== 2'd0) begin failures++; $display("FAIL basic_idx_state got=%0d/%0d exp=3/0", pat_idx, dbg_state); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
  endtask

  task automatic test_wrap;
    bit ok;
    exp_q = '{8'd14, 8'd15, 8'd0, 8'd1};
    do_start(4'd14, 5'd4);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=no_done exp=done"); end
    checks++; if (addr_q.size() != 4 || got_q.size() != 4) begin failures++; $display("FAIL wrap_sizes got=%0d/%0d exp=4/4", addr_q.size(), got_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size() && i < got_q.size(); i++) begin
      checks++; if ({4'd0, addr_q[i]} !== exp_q[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, addr_q[i], exp_q[i]); end
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bus.pat_ready = 1'b1;
    do_start(4'd0, 5'd10);
    repeat (4) @(posedge clk);
    #1;
    bus.pat_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.pat_valid !== 1'b1 || bus.pat_data !== WS'(got_q.size())) begin failures++; $display("FAIL bp_hold[%0d] got=%0b/%0h exp=1/%0h", c, bus.pat_valid, bus.pat_data, got_q.size()); end
      checks++; if (bus.mem_EN !== 1'b0) begin failures++; $display("FAIL bp_stall_EN[%0d] got=%0b exp=0", c, bus.mem_EN); end
      @(posedge clk); #1;
    end
    bus.pat_ready = 1'b1;
    #1;
    checks++; if (bus.mem_EN !== 1'b1 || bus.mem_add !== 4'd4) begin failures++; $display("FAIL bp_resume got=%0b/%0h exp=1/4", bus.mem_EN, bus.mem_add); end
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (max_occ > 2) begin failures++; $display("FAIL bp_outstanding got=%0d exp<=2", max_occ); end
    checks++; if (got_q.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      checks++; if (got_q[i] !== WS'(i)) begin failures++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", i, got_q[i], i); end
    end
  endtask

  task automatic test_zero_full;
    bit ok;
    int bad;
    do_start(4'd3, 5'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.mem_EN !== 1'b0) begin failures++; $display("FAIL zero_done got=%0b/%0b/%0b exp=1/0/0", done, busy, bus.mem_EN); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (addr_q.size() != 0) begin failures++; $display("FAIL zero_no_reads got=%0d exp=0", addr_q.size()); end
    do_start(4'd5, 5'd16);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=no_done exp=done"); end
    bad = 0;
    for (int a = 0; a < 16; a++) if (rd_cnt[a] != 1) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL full_read_once got=%0d_bad exp=0", bad); end
    checks++; if (got_q.size() != 16 || pat_idx !== 5'd16) begin failures++; $display("FAIL full_count got=%0d/%0d exp=16/16", got_q.size(), pat_idx); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      checks++; if (got_q[i] !== WS'((5 + i) % 16)) begin failures++; $display("FAIL full_data[%0d] got=%0h exp=%0h", i, got_q[i], (5 + i) % 16); end
    end
  endtask

  task automatic test_abort;
    bit ok;
    bus.pat_ready = 1'b0;
    do_start(4'd7, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.pat_valid !== 1'b1 || bus.pat_data !== 8'd7) begin failures++; $display("FAIL abort_pre got=%0b/%0h exp=1/7", bus.pat_valid, bus.pat_data); end
    abort = 1'b1;
    #1;
    checks++; if (bus.mem_EN !== 1'b0) begin failures++; $display("FAIL abort_EN got=%0b exp=0", bus.mem_EN); end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (bus.pat_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_next got=%0b/%0b exp=0/0", bus.pat_valid, done); end
    checks++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL abort_idle got=%0b/%0d exp=0/0", busy, dbg_state); end
    @(posedge clk); #1;
    checks++; if (bus.pat_valid !== 1'b0) begin failures++; $display("FAIL abort_flush got=%0b exp=0", bus.pat_valid); end
    bus.pat_ready = 1'b1;
    do_start(4'd9, 5'd2);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_restart_timeout got=no_done exp=done"); end
    checks++; if (got_q.size() != 2 || pat_idx !== 5'd2) begin failures++; $display("FAIL abort_restart_count got=%0d/%0d exp=2/2", got_q.size(), pat_idx); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      checks++; if (got_q[i] !== WS'(9 + i)) begin failures++; $display("FAIL abort_restart_data[%0d] got=%0h exp=%0h", i, got_q[i], 9 + i); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bus.pat_ready = 1'b1;
    do_start(4'd0, 5'd8);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL rstmid_fetch got=%0d exp=1", dbg_state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_EN !== 1'b0 || bus.mem_add !== 4'd0) begin failures++; $display("FAIL rstmid_mem got=%0b/%0h exp=0/0", bus.mem_EN, bus.mem_add); end
    checks++; if (bus.pat_valid !== 1'b0 || bus.pat_data !== 8'd0) begin failures++; $display("FAIL rstmid_pat got=%0b/%0h exp=0/0", bus.pat_valid, bus.pat_data); end
    checks++; if (pat_idx !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got=%0d/%0b/%0b exp=0/0/0", pat_idx, busy, done); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(4'd2, 5'd3);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_rerun_timeout got=no_done exp=done"); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL rstmid_rerun_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      checks++; if (got_q[i] !== WS'(2 + i)) begin failures++; $display("FAIL rstmid_rerun_data[%0d] got=%0h exp=%0h", i, got_q[i], 2 + i); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = WS'(i);
    bus.pat_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_full();
    test_abort();
    test_reset_mid();
    checks++; if (rw_seen) begin failures++; $display("FAIL mem_RW got=1 exp=0"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
